fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the immediate generator and decoder. It owns the program counter, issues one word-aligned read at a time to instruction memory, and presents the returned instruction word with its PC to decode through a valid/ready handshake. Branch and jump resolution re-steers it through a redirect port, and it drops any in-flight response made stale by that redirect.

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word-aligned read at a time,
// and hands each returned word to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        pc_aligned;

    assign pc_aligned  = (pc[1:0] == 2'b00);
    assign imem_addr   = pc;
    assign imem_req    = (state == FETCH) && pc_aligned && !redirect && !rst;
    assign fetch_fault = (state == FAULT);

    // A redirect wins over everything else; a read still in flight at that
    // moment must be drained so its stale data never reaches decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
            if (((state == WAIT) || (state == DRAIN)) && !imem_rvalid) begin
                state <= DRAIN;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!pc_aligned) begin
                        state <= FAULT;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: per-cycle vector table plus a latency-3 drain
// sequence, with a scoreboard checking every decode transfer.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    int lat = 1;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } xfer_t;

    vec_t  vecs[$];
    xfer_t sb[$];

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd,
                                input logic [31:0] rp, input logic rq,
                                input logic [31:0] ad, input logic v,
                                input logic [31:0] ip, input logic f);
        vec_t t;
        t.rst = r; t.ready = rdy; t.redir = rd; t.rpc = rp;
        t.req = rq; t.addr = ad; t.valid = v; t.ipc = ip; t.fault = f;
        return t;
    endfunction

    // Memory model with programmable latency; it knows nothing of redirects,
    // so stale responses still arrive and must be dropped by the DUT.
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    always @(posedge clk) begin
        if (rst) begin
            pend        <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memWord(paddr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("[TB] FAIL req_outstanding: got second request at %h, required none", imem_addr);
                end
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= memWord(imem_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end
        end
    end

    // Scoreboard: every accepted instruction must match the oldest expected one.
    always @(negedge clk) begin
        #2;
        if (!rst && inst_valid && inst_ready && !redirect) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL xfer_unexpected: got pc %h inst %h, required no transfer", inst_pc, inst);
            end else begin
                xfer_t e;
                e = sb.pop_front();
                if (inst_pc !== e.pc || inst !== e.word) begin
                    errors++;
                    $display("[TB] FAIL xfer: got pc %h inst %h, required pc %h inst %h", inst_pc, inst, e.pc, e.word);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        xfer_t e;
        @(negedge clk);
        rst         = v.rst;
        inst_ready  = v.ready;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        if (v.valid && v.ready && !v.redir && !v.rst) begin
            e.pc   = v.ipc;
            e.word = memWord(v.ipc);
            sb.push_back(e);
        end
        #1;
        checkOutput($sformatf("c%0d_req", idx), {31'h0, imem_req}, {31'h0, v.req});
        checkOutput($sformatf("c%0d_addr", idx), imem_addr, v.addr);
        checkOutput($sformatf("c%0d_valid", idx), {31'h0, inst_valid}, {31'h0, v.valid});
        checkOutput($sformatf("c%0d_inst_pc", idx), inst_pc, v.ipc);
        checkOutput($sformatf("c%0d_fault", idx), {31'h0, fetch_fault}, {31'h0, v.fault});
    endtask

    initial begin
        rst         = 1'b1;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // rst, ready, redir, rpc, req, addr, valid, inst_pc, fault
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h4, 1, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h4, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h4, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h8, 1, 32'h4, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h8, 0, 32'h4, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h8, 0, 32'h4, 0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0, 0, 0, 32'h0, 0, 32'hC, 1, 32'h8, 0));
        end
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'hC, 1, 32'h8, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'hC, 0, 32'h8, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'hC, 0, 32'h8, 0));
        vecs.push_back(mk(0, 1, 1, 32'h40, 0, 32'h10, 1, 32'hC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h40, 0, 32'hC, 0));
        vecs.push_back(mk(0, 1, 1, 32'h80, 0, 32'h40, 0, 32'hC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h80, 0, 32'hC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h80, 0, 32'hC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h84, 1, 32'h80, 0));
        vecs.push_back(mk(0, 1, 1, 32'h102, 0, 32'h84, 0, 32'h80, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h102, 0, 32'h80, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h102, 0, 32'h80, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h102, 0, 32'h80, 1));
        vecs.push_back(mk(0, 1, 1, 32'h200, 0, 32'h102, 0, 32'h80, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h200, 0, 32'h80, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h200, 0, 32'h80, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h204, 1, 32'h200, 0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h204, 0, 32'h200, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h200, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'hFFFF_FFFC, 0, 32'h200, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h0, 0, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 1, 32'h0, 0, 32'h0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_req", {31'h0, imem_req}, 32'h0);
        checkOutput("reset_inst", inst, 32'h0000_0013);
        checkOutput("reset_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("reset_inst_pc", inst_pc, 32'h0);
        checkOutput("reset_fault", {31'h0, fetch_fault}, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("post_reset_inst", inst, 32'h0000_0013);

        // Redirect while a latency-3 read is in flight: stale data is drained.
        @(negedge clk);
        rst = 1'b1;
        lat = 3;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("drain_req0", {31'h0, imem_req}, 32'h1);
        checkOutput("drain_addr0", imem_addr, 32'h0);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        checkOutput("drain_req_redirect", {31'h0, imem_req}, 32'h0);
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            checkOutput($sformatf("drain_req_d%0d", k), {31'h0, imem_req}, 32'h0);
            checkOutput($sformatf("drain_valid_d%0d", k), {31'h0, inst_valid}, 32'h0);
            checkOutput($sformatf("drain_addr_d%0d", k), imem_addr, 32'h100);
        end
        @(negedge clk);
        sb.push_back('{pc: 32'h100, word: memWord(32'h100)});
        #1;
        checkOutput("drain_req_new", {31'h0, imem_req}, 32'h1);
        checkOutput("drain_addr_new", imem_addr, 32'h100);
        checkOutput("drain_valid_new", {31'h0, inst_valid}, 32'h0);
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        #3;
        checkOutput("scoreboard_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
